// File: rtl/i_type.sv
// I-type ALU: combinational result plus a registered copy and valid flag.
// Optional encoding checker enabled by defining I_TYPE_ILLEGAL_CHK_EN.
module i_type (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] idata,
   input  logic [31:0] iaddr,
   input  logic [31:0] imm,
   input  logic [31:0] rv1,
   input  logic [31:0] rv2,
   output logic [31:0] regdata_I,
   output logic [31:0] regdata_I_q,
   output logic        valid_q,
   output logic        illegal
);

   localparam int unsigned XLEN      = 32;
   localparam int unsigned SHAMT_W   = 5;
   localparam logic [6:0]  OP_IMM    = 7'b0010011;
   localparam logic [6:0]  F7_ZERO   = 7'b0000000;
   localparam logic [6:0]  F7_ARITH  = 7'b0100000;

   localparam logic [2:0]  F3_ADDI   = 3'b000;
   localparam logic [2:0]  F3_SLLI   = 3'b001;
   localparam logic [2:0]  F3_SLTI   = 3'b010;
   localparam logic [2:0]  F3_SLTIU  = 3'b011;
   localparam logic [2:0]  F3_XORI   = 3'b100;
   localparam logic [2:0]  F3_SRXI   = 3'b101;
   localparam logic [2:0]  F3_ORI    = 3'b110;
   localparam logic [2:0]  F3_ANDI   = 3'b111;

   logic [2:0]         funct3;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    regdata_I_d;
   logic               valid_d;

   assign funct3 = idata[14:12];
   assign shamt  = imm[SHAMT_W-1:0];

   // Result selection; unmatched (including unknown) selects fall to zero.
   always_comb begin
      regdata_I = '0;
      case (funct3)
         F3_ADDI:  regdata_I = rv1 + imm;
         F3_SLTI:  regdata_I = {31'd0, ($signed(rv1) < $signed(imm))};
         F3_SLTIU: regdata_I = {31'd0, (rv1 < imm)};
         F3_XORI:  regdata_I = rv1 ^ imm;
         F3_ORI:   regdata_I = rv1 | imm;
         F3_ANDI:  regdata_I = rv1 & imm;
         F3_SLLI:  regdata_I = rv1 << shamt;
         F3_SRXI: begin
            case (idata[30])
               1'b0:    regdata_I = rv1 >> shamt;
               1'b1:    regdata_I = XLEN'($signed(rv1) >>> shamt);
               default: regdata_I = '0;
            endcase
         end
         default:  regdata_I = '0;
      endcase
   end

`ifdef I_TYPE_ILLEGAL_CHK_EN
   logic [6:0] funct7;
   assign funct7 = idata[31:25];

   // Flags non OP-IMM opcodes and bad funct7 on the shift encodings.
   always_comb begin
      illegal = 1'b0;
      if (idata[6:0] != OP_IMM) begin
         illegal = 1'b1;
      end
      if ((funct3 == F3_SLLI) && (funct7 != F7_ZERO)) begin
         illegal = 1'b1;
      end
      if ((funct3 == F3_SRXI) && (funct7 != F7_ZERO) && (funct7 != F7_ARITH)) begin
         illegal = 1'b1;
      end
   end
`else
   localparam logic [6:0] UNUSED_CONSTS = OP_IMM ^ F7_ZERO ^ F7_ARITH;
   assign illegal = 1'b0;
`endif

   // Ignored inputs and idata fields outside the decode.
   logic unused_inputs;
`ifdef I_TYPE_ILLEGAL_CHK_EN
   assign unused_inputs = ^{iaddr, rv2, idata};
`else
   assign unused_inputs = ^{iaddr, rv2, idata, UNUSED_CONSTS};
`endif

   always_comb begin
      regdata_I_d = regdata_I;
      valid_d     = 1'b1;
      if (!reset) begin
         regdata_I_d = '0;
         valid_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      regdata_I_q <= regdata_I_d;
      valid_q     <= valid_d;
   end

endmodule

// File: tb/tb_i_type.sv
// Randomized self-checking bench for i_type against an arithmetic reference model.
module tb_i_type;

   logic        clk;
   logic        reset;
   logic [31:0] idata;
   logic [31:0] iaddr;
   logic [31:0] imm;
   logic [31:0] rv1;
   logic [31:0] rv2;
   logic [31:0] regdata_I;
   logic [31:0] regdata_I_q;
   logic        valid_q;
   logic        illegal;

   int unsigned n_checks;
   int unsigned n_pass;

   i_type dut (
      .clk         (clk),
      .reset       (reset),
      .idata       (idata),
      .iaddr       (iaddr),
      .imm         (imm),
      .rv1         (rv1),
      .rv2         (rv2),
      .regdata_I   (regdata_I),
      .regdata_I_q (regdata_I_q),
      .valid_q     (valid_q),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model built from the instruction semantics with plain arithmetic.
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic b30,
                                           input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      logic [63:0] prod;
      logic [31:0] fill;
      sh = 32'(b & 32'h1f);
      case (f3)
         3'd0: ref_alu = 32'(64'(a) + 64'(b));
         3'd2: ref_alu = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         3'd3: ref_alu = (a < b) ? 32'd1 : 32'd0;
         3'd4: ref_alu = a ^ b;
         3'd6: ref_alu = a | b;
         3'd7: ref_alu = a & b;
         3'd1: begin
            prod    = 64'(a) * (64'd1 << sh);
            ref_alu = prod[31:0];
         end
         default: begin
            fill = (b30 && a[31]) ? ~(32'hffff_ffff >> sh) : 32'd0;
            ref_alu = (a >> sh) | fill;
         end
      endcase
   endfunction

   function automatic logic ref_illegal(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
`ifdef I_TYPE_ILLEGAL_CHK_EN
      logic bad;
      bad = (op != 7'b0010011);
      if (f3 == 3'd1 && f7 != 7'd0) bad = 1'b1;
      if (f3 == 3'd5 && !(f7 == 7'd0 || f7 == 7'h20)) bad = 1'b1;
      return bad;
`else
      return 1'b0;
`endif
   endfunction

   // Applies one instruction with the given reset level and checks both views.
   task automatic run_vec(input logic rst_val, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      logic [9:0]  rnd;
      @(negedge clk);
      rnd   = 10'($urandom);
      reset = rst_val;
      idata = {f7, rnd[4:0], rnd[9:5], f3, 5'($urandom), op};
      iaddr = $urandom;
      rv2   = $urandom;
      rv1   = a;
      imm   = b;
      #1;
      exp = ref_alu(f3, f7[5], a, b);
      check("comb", regdata_I, exp);
      check("illegal", 32'(illegal), 32'(ref_illegal(op, f3, f7)));
      @(posedge clk);
      #1;
      check("reg", regdata_I_q, rst_val ? exp : 32'd0);
      check("valid", 32'(valid_q), 32'(rst_val));
   endtask

   localparam logic [6:0] OP = 7'b0010011;

   initial begin
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [6:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int unsigned sel;
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      idata    = '0;
      iaddr    = '0;
      imm      = '0;
      rv1      = '0;
      rv2      = '0;

      // Held reset for two clocks; combinational path must stay live.
      run_vec(1'b0, OP, 3'd0, 7'd0, 32'd5, 32'd7);
      run_vec(1'b0, OP, 3'd4, 7'd0, 32'd679, 32'd91);
      check("rst_comb", regdata_I, 32'd764);
      run_vec(1'b1, OP, 3'd4, 7'd0, 32'd679, 32'd91);
      check("rel_reg", regdata_I_q, 32'd764);

      run_vec(1'b1, OP, 3'd0, 7'd0, 32'd1073741824, 32'd1073741824);
      check("addi_wrap", regdata_I, 32'h8000_0000);
      run_vec(1'b1, OP, 3'd2, 7'd0, 32'd989, 32'd295);
      check("slti_a", regdata_I, 32'd0);
      run_vec(1'b1, OP, 3'd3, 7'd0, 32'hffff_ffff, 32'd1);
      check("sltiu", regdata_I, 32'd0);
      run_vec(1'b1, OP, 3'd2, 7'd0, 32'hffff_ffff, 32'd1);
      check("slti_b", regdata_I, 32'd1);
      run_vec(1'b1, OP, 3'd6, 7'd0, 32'd234, 32'd592);
      check("ori", regdata_I, 32'd762);
      run_vec(1'b1, OP, 3'd7, 7'd0, 32'd503, 32'd746);
      check("andi", regdata_I, 32'd226);
      run_vec(1'b1, OP, 3'd1, 7'd0, 32'd843, 32'd750);
      check("slli", regdata_I, 32'd13811712);
      run_vec(1'b1, OP, 3'd5, 7'd0, 32'd949, 32'd3);
      check("srli", regdata_I, 32'd118);
      run_vec(1'b1, OP, 3'd5, 7'h20, 32'hffff_fffb, 32'd3);
      check("srai", regdata_I, 32'hffff_ffff);
      run_vec(1'b1, OP, 3'd5, 7'h20, 32'h8000_0010, 32'd32);
      check("sh0_sra", regdata_I, 32'h8000_0010);
      run_vec(1'b1, OP, 3'd1, 7'd0, 32'h1234_5678, 32'hffff_ffe0);
      check("sh0_sll", regdata_I, 32'h1234_5678);
      run_vec(1'b1, OP, 3'd1, 7'h20, 32'd1, 32'd1);
      run_vec(1'b1, 7'b0110011, 3'd0, 7'd0, 32'd1, 32'd1);

      // Random mix including bad encodings and occasional mid-stream reset.
      for (int i = 0; i < 300; i++) begin
         f3  = 3'($urandom);
         sel = $urandom_range(0, 9);
         f7  = (sel < 4) ? 7'd0 : (sel < 8) ? 7'h20 : 7'($urandom);
         op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OP;
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_vec($urandom_range(0, 9) != 0, op, f3, f7, a, b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i_type.md
I_TYPE -- requirements
Module: i_type

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and reset as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 reset  input  1  synchronous active-low reset; sampled on rising clk.
REQ-004 idata  input  32  instruction word; bits [14:12] are funct3, bit [30] selects arithmetic shift, bits [31:25] are funct7, bits [6:0] are opcode.
REQ-005 iaddr  input  32  instruction address; accepted and ignored.
REQ-006 imm  input  32  signed, sign-extended I-type immediate.
REQ-007 rv1  input  32  signed source register 1 value.
REQ-008 rv2  input  32  source register 2 value; accepted and ignored.
REQ-009 regdata_I  output  32  combinational I-type ALU result.
REQ-010 regdata_I_q  output  32  regdata_I registered on rising clk.
REQ-011 valid_q  output  1  registered-result-valid flag.
REQ-012 illegal  output  1  combinational illegal-encoding flag; see Configuration.

Function
REQ-013 regdata_I SHALL depend only on idata[14:12], idata[30], rv1 and imm, with no dependence on the opcode bits or the clock.
REQ-014 funct3 000 (ADDI): rv1 + imm, 32-bit two's-complement, wrap on overflow, no flag.
REQ-015 funct3 010 (SLTI): 32'd1 if signed rv1 < signed imm, else 0.
REQ-016 funct3 011 (SLTIU): 32'd1 if unsigned rv1 < unsigned imm, else 0.
REQ-017 funct3 100 (XORI): rv1 ^ imm.
REQ-018 funct3 110 (ORI): rv1 | imm.
REQ-019 funct3 111 (ANDI): rv1 & imm.
REQ-020 funct3 001 (SLLI): rv1 << imm[4:0]; imm[31:5] is ignored.
REQ-021 funct3 101 with idata[30]=0 (SRLI): logical right shift of rv1 by imm[4:0], zero fill.
REQ-022 funct3 101 with idata[30]=1 (SRAI): arithmetic right shift of rv1 by imm[4:0], replicating rv1[31].
REQ-023 Shift amount 0 SHALL return rv1 unchanged.
REQ-024 If any result-determining input bit is X/Z, regdata_I SHALL be 32'd0 (default branch); there are no latches.
REQ-025 On each rising clk with reset=1: regdata_I_q <= regdata_I and valid_q <= 1.
REQ-026 Latency: regdata_I is available in 0 cycles; regdata_I_q is available 1 cycle later.

Reset
REQ-027 On a rising clk with reset=0: regdata_I_q <= 0 and valid_q <= 0; this takes priority over the capture in REQ-025.
REQ-028 Reset SHALL NOT affect regdata_I or illegal, which stay combinational.
REQ-029 Asserting reset mid-stream SHALL discard any pending registered result on that edge.

Configuration
REQ-030 With macro I_TYPE_ILLEGAL_CHK_EN defined, illegal SHALL be 1 in any of these cases:
- opcode != 7'b0010011;
- funct3=001 with idata[31:25] != 0;
- funct3=101 with idata[31:25] not 0000000 or 0100000.
REQ-031 With I_TYPE_ILLEGAL_CHK_EN defined, regdata_I SHALL be unaffected by illegal.
REQ-032 Without I_TYPE_ILLEGAL_CHK_EN, illegal SHALL be tied to 0 and no checking logic is built.

Verification
REQ-033 ADDI, rv1=1073741824, imm=1073741824 -> regdata_I=32'h80000000 (wrap).
REQ-034 SLTI, rv1=989, imm=295 -> 0; SLTIU, rv1=-1, imm=1 -> 0; SLTI, rv1=-1, imm=1 -> 1.
REQ-035 XORI 679^91 -> 764; ORI 234|592 -> 762; ANDI 503&746 -> 226.
REQ-036 SLLI, rv1=843, imm=750 (shamt 14) -> 13811712; SRLI, rv1=949, imm=3 -> 118; SRAI (idata[30]=1), rv1=-5, imm=3 -> -1 (32'hFFFFFFFF).
REQ-037 Hold reset=0 for 2 clks, then release -> regdata_I_q=0, valid_q=0 during reset; one clk after release, regdata_I_q equals the prior regdata_I and valid_q=1.
REQ-038 With I_TYPE_ILLEGAL_CHK_EN defined, SLLI with idata[31:25]=7'h20 -> illegal=1; SRAI with valid encoding -> illegal=0.
